mem_map_bus_bridge: RTL and testbench
=====================================

Name: mem_map_bus_bridge

Overview:
Parametrised, registered successor to the combinational memory-map decoder. Sits between the single-cycle/multi-cycle RISC-V core's data port and N memory-mapped slaves (data memory, program memory, GPIO, future peripherals). Adds:
- a request/response handshake and wait-state support per slave
- a timeout watchdog
- an error response for unmapped, misaligned or read-only-violating accesses

Parameters:
NUM_SLAVES, 3, number of slave regions (1..8)
ADDR_W, 32, address width
DATA_W, 32, data width
REGION_BASE, {32'h1001_0024, 32'h0040_0000, 32'h1000_0000}, flattened NUM_SLAVES*ADDR_W inclusive base addresses; slave 0 in LSBs
REGION_LIMIT, {32'h1001_002B, 32'h0FFF_FFFF, 32'h1001_0023}, flattened inclusive limit addresses
REGION_RO, 3'b010, per-region read-only mask; 1 = writes rejected
TIMEOUT, 16, cycles allowed in ACCESS before an error response
TIMEOUT_W, 5, counter width (>= clog2(TIMEOUT)+1)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
cpu_req_valid  in  1  core requests an access
cpu_req_write  in  1  1 = write, 0 = read
cpu_addr  in  ADDR_W  byte address from core
cpu_wdata  in  DATA_W  write data from core
cpu_ready  out  1  bridge can accept a request (IDLE only)
cpu_rsp_valid  out  1  one-cycle response strobe
cpu_rsp_err  out  1  response is an error (qualified by cpu_rsp_valid)
cpu_rdata  out  DATA_W  read data (qualified by cpu_rsp_valid)
slv_sel  out  NUM_SLAVES  one-hot chip select
slv_we  out  1  write enable to selected slave
slv_addr  out  ADDR_W  word offset ((addr - base) >> 2)
slv_wdata  out  DATA_W  write data to selected slave
slv_rdata  in  NUM_SLAVES*DATA_W  flattened slave read data
slv_ready  in  NUM_SLAVES  slave completion, per slave

Behaviour:
- Reset: state = IDLE; all outputs 0 except cpu_ready = 1 from the first cycle after reset deasserts. Reset mid-transaction aborts at the next edge, drops slv_sel and issues no response.
- FSM states: IDLE, ACCESS, RESP, ERR.
- IDLE:
  - cpu_ready = 1. Handshake = cpu_req_valid & cpu_ready.
  - Decode is combinational on cpu_addr; the result is registered at the handshake edge.
  - Region match is inclusive: base <= addr <= limit. If regions overlap, the lowest index wins.
  - Error conditions: no match, cpu_addr[1:0] != 0, or write to a REGION_RO region. On error -> ERR. Otherwise -> ACCESS.
- ACCESS:
  - slv_sel is one-hot for the matched slave. slv_we, slv_addr and slv_wdata are held stable from registers. cpu_ready = 0.
  - Timeout counter clears on entry and increments each cycle.
  - If slv_ready[sel] = 1: capture slv_rdata of the selected slave into cpu_rdata (0 on writes), then -> RESP.
  - Else if counter == TIMEOUT-1: -> ERR.
  - Ready from non-selected slaves is ignored.
- RESP: cpu_rsp_valid = 1, cpu_rsp_err = 0 for exactly one cycle; slv_sel = 0; then -> IDLE.
- ERR: cpu_rsp_valid = 1, cpu_rsp_err = 1, cpu_rdata = 0 for one cycle; slv_sel = 0; then -> IDLE.
- Latency: handshake at edge N, select asserted during cycle N+1. If ready in that cycle, rsp_valid is in cycle N+2. Decode errors give rsp_valid in cycle N+1.
- Arithmetic: offset = addr - base in ADDR_W bits, logical right shift by 2; upper bits zero.
- Address boundaries: base and limit both match; limit+1 falls through to the next region or to error.
- Back-to-back: a new request can be accepted in the IDLE cycle immediately after RESP/ERR; throughput is one access per 3 cycles minimum.
- cpu_req_valid outside IDLE is ignored. The core holds the request until the handshake.

Decomposition:
- Package mem_map_pkg:
  - FSM state enum (2 bits)
  - default region base/limit localparams for DATA, GPIO and PROGRAM
  - RESERVED range constant 0x0000_0000–0x003F_FFFF (always error)
- Sub-module mem_region_match: one instance per region via generate. Inputs addr, base, limit. Outputs hit and offset.

Test Plan:
- Read 0x1000_0008, slave0 ready in the first ACCESS cycle, slv_rdata0 = 0xCAFE_F00D -> slv_sel = 3'b001, slv_addr = 2; rsp_valid two cycles after the handshake; cpu_rdata = 0xCAFE_F00D; err = 0.
- Write 0x1001_0028, data 0x0000_00FF, slave2 ready after 3 wait cycles -> slv_sel = 3'b100, slv_addr = 1, slv_we = 1; rsp_valid 5 cycles after the handshake; err = 0.
- Write 0x0040_0000 (RO program region) -> no slv_sel; rsp_valid and err = 1 one cycle after the handshake. Read of the same address -> slv_sel = 3'b010, slv_addr = 0.
- Read 0x0000_1000 (reserved), then 0x1001_0022 (misaligned) -> each gives err = 1 and cpu_rdata = 0; boundary reads 0x1001_0020 and 0x1001_0024 hit slaves 0 and 2 respectively.
- Read 0x1000_0000 with slave0 never ready -> slv_sel held 16 cycles, then ERR with err = 1; cpu_ready returns the following cycle.
- Assert rst during ACCESS with a slave stalled -> next cycle slv_sel = 0, no rsp_valid, cpu_ready = 1 after release; a following read completes normally.

Source files
------------

// File: rtl/mem_map_pkg.sv
// Shared types and default address map for the memory-mapped bus bridge.
package mem_map_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2,
    ST_ERR    = 2'd3
  } bridge_state_e;

  localparam logic [31:0] DATA_BASE      = 32'h1000_0000;
  localparam logic [31:0] DATA_LIMIT     = 32'h1001_0023;
  localparam logic [31:0] PROG_BASE      = 32'h0040_0000;
  localparam logic [31:0] PROG_LIMIT     = 32'h0FFF_FFFF;
  localparam logic [31:0] GPIO_BASE      = 32'h1001_0024;
  localparam logic [31:0] GPIO_LIMIT     = 32'h1001_002B;
  localparam logic [31:0] RESERVED_BASE  = 32'h0000_0000;
  localparam logic [31:0] RESERVED_LIMIT = 32'h003F_FFFF;

  function automatic logic is_word_aligned(input logic [1:0] i_lsb);
    return (i_lsb == 2'b00);
  endfunction

endpackage

// File: rtl/mem_region_match.sv
// Inclusive base/limit comparator for one slave region plus its word offset.
module mem_region_match #(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [ADDR_W-1:0] i_base,
  input  logic [ADDR_W-1:0] i_limit,
  output logic              o_hit,
  output logic [ADDR_W-1:0] o_offset
);

  assign o_hit    = (i_addr >= i_base) && (i_addr <= i_limit);
  assign o_offset = (i_addr - i_base) >> 2;

endmodule

// File: rtl/mem_map_bus_bridge.sv
// Registered request/response bridge from the core data port to N slaves,
// with per-slave wait states, a timeout watchdog and error responses.
module mem_map_bus_bridge
  import mem_map_pkg::*;
#(
  parameter int NUM_SLAVES = 3,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] REGION_BASE  = {GPIO_BASE, PROG_BASE, DATA_BASE},
  parameter logic [NUM_SLAVES*ADDR_W-1:0] REGION_LIMIT = {GPIO_LIMIT, PROG_LIMIT, DATA_LIMIT},
  parameter logic [NUM_SLAVES-1:0]        REGION_RO    = 3'b010,
  parameter int TIMEOUT   = 16,
  parameter int TIMEOUT_W = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cpu_req_valid,
  input  logic                         cpu_req_write,
  input  logic [ADDR_W-1:0]            cpu_addr,
  input  logic [DATA_W-1:0]            cpu_wdata,
  output logic                         cpu_ready,
  output logic                         cpu_rsp_valid,
  output logic                         cpu_rsp_err,
  output logic [DATA_W-1:0]            cpu_rdata,
  output logic [NUM_SLAVES-1:0]        slv_sel,
  output logic                         slv_we,
  output logic [ADDR_W-1:0]            slv_addr,
  output logic [DATA_W-1:0]            slv_wdata,
  input  logic [NUM_SLAVES*DATA_W-1:0] slv_rdata,
  input  logic [NUM_SLAVES-1:0]        slv_ready
);

  localparam logic [TIMEOUT_W-1:0] L_TMO_LAST = TIMEOUT_W'(TIMEOUT - 1);

  bridge_state_e r_state, w_next;

  logic [NUM_SLAVES-1:0] r_sel;
  logic                  r_we;
  logic [ADDR_W-1:0]     r_addr;
  logic [DATA_W-1:0]     r_wdata;
  logic [DATA_W-1:0]     r_rdata;
  logic [TIMEOUT_W-1:0]  r_cnt;

  logic [NUM_SLAVES-1:0] w_hit;
  logic [ADDR_W-1:0]     w_offset [NUM_SLAVES];
  logic [NUM_SLAVES-1:0] w_dec_sel;
  logic [ADDR_W-1:0]     w_dec_offset;
  logic                  w_dec_ro;
  logic                  w_dec_err;
  logic                  w_hs;
  logic                  w_sel_ready;
  logic [DATA_W-1:0]     w_sel_rdata;

  for (genvar g = 0; g < NUM_SLAVES; g++) begin : g_match
    mem_region_match #(.ADDR_W(ADDR_W)) u_match (
      .i_addr  (cpu_addr),
      .i_base  (REGION_BASE[g*ADDR_W +: ADDR_W]),
      .i_limit (REGION_LIMIT[g*ADDR_W +: ADDR_W]),
      .o_hit   (w_hit[g]),
      .o_offset(w_offset[g])
    );
  end

  // Walk from the top index down so the lowest matching region wins on overlap.
  always_comb begin
    w_dec_sel    = '0;
    w_dec_offset = '0;
    w_dec_ro     = 1'b0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (w_hit[i]) begin
        w_dec_sel    = NUM_SLAVES'(1) << i;
        w_dec_offset = w_offset[i];
        w_dec_ro     = REGION_RO[i];
      end
    end
  end

  assign w_dec_err = (w_dec_sel == '0) || !is_word_aligned(cpu_addr[1:0]) ||
                     (cpu_req_write && w_dec_ro) ||
                     (cpu_addr <= ADDR_W'(RESERVED_LIMIT));
  assign w_hs        = cpu_req_valid && (r_state == ST_IDLE);
  assign w_sel_ready = |(slv_ready & r_sel);

  always_comb begin
    w_sel_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (r_sel[i]) begin
        w_sel_rdata = slv_rdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (cpu_req_valid) w_next = w_dec_err ? ST_ERR : ST_ACCESS;
        else               w_next = ST_IDLE;
      end
      ST_ACCESS: begin
        if (w_sel_ready)              w_next = ST_RESP;
        else if (r_cnt == L_TMO_LAST) w_next = ST_ERR;
        else                          w_next = ST_ACCESS;
      end
      ST_RESP: w_next = ST_IDLE;
      ST_ERR:  w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Request fields are frozen at the handshake so the slave sees a stable access.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sel   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_cnt   <= '0;
    end else if (w_hs) begin
      r_sel   <= w_dec_err ? '0 : w_dec_sel;
      r_we    <= cpu_req_write;
      r_addr  <= w_dec_offset;
      r_wdata <= cpu_wdata;
      r_rdata <= '0;
      r_cnt   <= '0;
    end else if (r_state == ST_ACCESS) begin
      r_cnt <= r_cnt + TIMEOUT_W'(1);
      if (w_sel_ready) r_rdata <= r_we ? '0 : w_sel_rdata;
    end
  end

  always_comb begin
    cpu_ready     = 1'b0;
    cpu_rsp_valid = 1'b0;
    cpu_rsp_err   = 1'b0;
    cpu_rdata     = '0;
    slv_sel       = '0;
    slv_we        = 1'b0;
    slv_addr      = '0;
    slv_wdata     = '0;
    case (r_state)
      ST_IDLE: cpu_ready = 1'b1;
      ST_ACCESS: begin
        slv_sel   = r_sel;
        slv_we    = r_we;
        slv_addr  = r_addr;
        slv_wdata = r_wdata;
      end
      ST_RESP: begin
        cpu_rsp_valid = 1'b1;
        cpu_rdata     = r_rdata;
      end
      ST_ERR: begin
        cpu_rsp_valid = 1'b1;
        cpu_rsp_err   = 1'b1;
      end
      default: cpu_ready = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_mem_map_bus_bridge.sv
// Directed plus randomized bench for mem_map_bus_bridge against an address-map model.
module tb_mem_map_bus_bridge;

  localparam int NS  = 3;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic           cpu_req_valid, cpu_req_write;
  logic [AW-1:0]  cpu_addr;
  logic [DW-1:0]  cpu_wdata;
  logic           cpu_ready, cpu_rsp_valid, cpu_rsp_err;
  logic [DW-1:0]  cpu_rdata;
  logic [NS-1:0]  slv_sel;
  logic           slv_we;
  logic [AW-1:0]  slv_addr;
  logic [DW-1:0]  slv_wdata;
  logic [NS*DW-1:0] slv_rdata;
  logic [NS-1:0]  slv_ready;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_base  [NS] = '{32'h1000_0000, 32'h0040_0000, 32'h1001_0024};
  logic [31:0] m_limit [NS] = '{32'h1001_0023, 32'h0FFF_FFFF, 32'h1001_002B};
  logic        m_ro    [NS] = '{1'b0, 1'b1, 1'b0};

  mem_map_bus_bridge dut (
    .clk(clk), .rst(rst),
    .cpu_req_valid(cpu_req_valid), .cpu_req_write(cpu_req_write),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready), .cpu_rsp_valid(cpu_rsp_valid),
    .cpu_rsp_err(cpu_rsp_err), .cpu_rdata(cpu_rdata),
    .slv_sel(slv_sel), .slv_we(slv_we), .slv_addr(slv_addr),
    .slv_wdata(slv_wdata), .slv_rdata(slv_rdata), .slv_ready(slv_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // First matching region in index order; error for reserved, unmapped, misaligned or RO write.
  task automatic model_decode(input logic wr, input logic [31:0] a,
                              output int idx, output logic err, output logic [31:0] off);
    idx = -1;
    off = 32'd0;
    for (int i = 0; i < NS; i++)
      if (idx < 0 && a >= m_base[i] && a <= m_limit[i]) begin
        idx = i;
        off = (a - m_base[i]) / 32'd4;
      end
    err = (idx < 0) || (a % 32'd4 != 32'd0) || (a < 32'h0040_0000) || (wr && m_ro[idx < 0 ? 0 : idx]);
  endtask

  // Starts at a negedge in IDLE; ends at the negedge of the following IDLE cycle.
  task automatic do_txn(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                        input int delay, input logic [NS*DW-1:0] rdv);
    int idx;
    logic err;
    logic [31:0] off;
    logic [NS-1:0] esel;
    logic tmo;
    logic [31:0] erd;
    model_decode(wr, a, idx, err, off);
    esel = err ? '0 : NS'(1) << idx;
    chk("ready_idle", {31'd0, cpu_ready}, 32'd1);
    cpu_req_valid = 1'b1; cpu_req_write = wr; cpu_addr = a; cpu_wdata = wd;
    slv_rdata = rdv;
    slv_ready = NS'($urandom) & ~esel;
    @(posedge clk); @(negedge clk);
    // Request lines are ignored outside IDLE, so scramble them.
    cpu_req_valid = 1'($urandom); cpu_addr = $urandom(); cpu_wdata = $urandom();
    cpu_req_write = 1'($urandom);
    if (err) begin
      chk("dec_err_valid", {31'd0, cpu_rsp_valid}, 32'd1);
      chk("dec_err_err", {31'd0, cpu_rsp_err}, 32'd1);
      chk("dec_err_rdata", cpu_rdata, 32'd0);
      chk("dec_err_sel", {29'd0, slv_sel}, 32'd0);
    end else begin
      for (int k = 0; k < TMO; k++) begin
        chk("acc_sel", {29'd0, slv_sel}, {29'd0, esel});
        chk("acc_we", {31'd0, slv_we}, {31'd0, wr});
        chk("acc_addr", slv_addr, off);
        chk("acc_wdata", slv_wdata, wd);
        chk("acc_ready", {31'd0, cpu_ready}, 32'd0);
        chk("acc_rspv", {31'd0, cpu_rsp_valid}, 32'd0);
        slv_ready = (NS'($urandom) & ~esel) | ((k == delay) ? esel : '0);
        @(posedge clk); @(negedge clk);
        if (k == delay) break;
      end
      tmo = (delay >= TMO);
      erd = (tmo || wr) ? 32'd0 : rdv[idx*DW +: DW];
      chk("rsp_valid", {31'd0, cpu_rsp_valid}, 32'd1);
      chk("rsp_err", {31'd0, cpu_rsp_err}, {31'd0, tmo});
      chk("rsp_rdata", cpu_rdata, erd);
      chk("rsp_sel", {29'd0, slv_sel}, 32'd0);
    end
    chk("rsp_ready", {31'd0, cpu_ready}, 32'd0);
    cpu_req_valid = 1'b0;
    slv_ready = '0;
    @(posedge clk); @(negedge clk);
    chk("idle_ready", {31'd0, cpu_ready}, 32'd1);
    chk("idle_rspv", {31'd0, cpu_rsp_valid}, 32'd0);
  endtask

  function automatic logic [NS*DW-1:0] rand_rd();
    logic [NS*DW-1:0] v;
    for (int i = 0; i < NS; i++) v[i*DW +: DW] = $urandom();
    return v;
  endfunction

  initial begin
    int r;
    logic [31:0] a;
    rst = 1'b1; cpu_req_valid = 1'b0; cpu_req_write = 1'b0;
    cpu_addr = '0; cpu_wdata = '0; slv_rdata = '0; slv_ready = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", {31'd0, cpu_ready}, 32'd1);
    chk("rst_rspv", {31'd0, cpu_rsp_valid}, 32'd0);
    chk("rst_err", {31'd0, cpu_rsp_err}, 32'd0);
    chk("rst_rdata", cpu_rdata, 32'd0);
    chk("rst_sel", {29'd0, slv_sel}, 32'd0);
    chk("rst_we", {31'd0, slv_we}, 32'd0);

    do_txn(1'b0, 32'h1000_0008, 32'd0, 0, {32'h1111_1111, 32'h2222_2222, 32'hCAFE_F00D});
    do_txn(1'b1, 32'h1001_0028, 32'h0000_00FF, 3, rand_rd());
    do_txn(1'b1, 32'h0040_0000, 32'h1234_5678, 0, rand_rd());
    do_txn(1'b0, 32'h0040_0000, 32'd0, 1, rand_rd());
    do_txn(1'b0, 32'h0000_1000, 32'd0, 0, rand_rd());
    do_txn(1'b0, 32'h1001_0022, 32'd0, 0, rand_rd());
    do_txn(1'b0, 32'h1001_0020, 32'd0, 0, rand_rd());
    do_txn(1'b0, 32'h1001_0024, 32'd0, 0, rand_rd());
    do_txn(1'b0, 32'h1000_0000, 32'd0, 99, rand_rd());

    // Reset while a slave stalls: selection drops, no response appears.
    cpu_req_valid = 1'b1; cpu_req_write = 1'b0; cpu_addr = 32'h1000_0000;
    slv_ready = '0;
    @(posedge clk); @(negedge clk);
    cpu_req_valid = 1'b0;
    chk("rst_mid_sel", {29'd0, slv_sel}, 32'd1);
    @(posedge clk); @(negedge clk);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("rst_mid_sel0", {29'd0, slv_sel}, 32'd0);
    chk("rst_mid_rspv", {31'd0, cpu_rsp_valid}, 32'd0);
    rst = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("rst_rel_ready", {31'd0, cpu_ready}, 32'd1);
    chk("rst_rel_rspv", {31'd0, cpu_rsp_valid}, 32'd0);
    do_txn(1'b0, 32'h1000_0010, 32'd0, 2, rand_rd());

    for (int n = 0; n < 60; n++) begin
      r = int'($urandom_range(0, NS - 1));
      case ($urandom_range(0, 5))
        0: a = m_base[r] + 32'd4 * $urandom_range(0, (m_limit[r] - m_base[r]) / 32'd4);
        1: a = m_base[r];
        2: a = m_limit[r] - 32'd3;
        3: a = m_limit[r] + 32'd1;
        4: a = $urandom();
        default: a = m_base[r] + 32'($urandom_range(1, 3));
      endcase
      do_txn(1'($urandom), a, $urandom(),
             ($urandom_range(0, 7) == 0) ? 40 : int'($urandom_range(0, 5)), rand_rd());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
